fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end with decoupling queue between inst SRAM and ID.
//  Owns the fetch PC and issues one SRAM read per cycle when credit allows.
//  Buffers {inst, pc} entries in a DEPTH-entry FIFO and hands them to ID via valid/allowin.
//  Flushes everything on redirect (branch / exception / ERET) and restarts at the target.
// PARAMETERS
//  DATA_W    32            instruction width
//  PC_W      32            PC / SRAM address width
//  DEPTH     4             queue entries; power of 2, >=2
//  RESET_PC  32'hbfc00000  first fetch address after reset
// PORTS
//  clk             in   1              clock, all state on posedge
//  resetn          in   1              asynchronous active-low reset
//  inst_sram_en    out  1              read request this cycle
//  inst_sram_wen   out  4              tied 4'b0
//  inst_sram_addr  out  PC_W           request address
//  inst_sram_wdata out  32             tied 0
//  inst_sram_rdata in   DATA_W         read data, valid the cycle after the request
//  redirect_valid  in   1              flush + restart fetch
//  redirect_pc     in   PC_W           restart address
//  ds_allowin      in   1              ID accepts an entry
//  fs_to_ds_valid  out  1              head entry valid
//  fs_to_ds_bus    out  BUS_W          {inst, pc}; BUS_W = DATA_W+PC_W (+1, see CONFIGURATION)
//  fq_count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async, immediate):
//   - fetch_pc=RESET_PC; count=0; inflight=0.
//   - inst_sram_en=0; fs_to_ds_valid=0; fq_count=0; bus contents don't-care.
//  Handshake and credit:
//   - pop = fs_to_ds_valid & ds_allowin.
//   - issue = (count + inflight - pop) < DEPTH. inst_sram_en=issue, addr=fetch_pc.
//   - On issue, fetch_pc <= fetch_pc+4, wrapping modulo 2^PC_W.
//  Latency:
//   - Request in cycle t; rdata sampled in t+1; entry written at end of t+1 with pc of t.
//   - Entry visible at head in t+2, so first fs_to_ds_valid is 2 cycles after first request.
//  Throughput:
//   - Sustained 1 entry/cycle while ds_allowin=1.
//  Queue:
//   - Circular FIFO, head/tail pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle leaves count unchanged, also at full or 1 entry.
//   - Push when full is impossible by credit; the bench asserts it never occurs.
//   - Empty: fs_to_ds_valid=0, pop ignored.
//  Redirect (redirect_valid=1 in cycle r):
//   - fs_to_ds_valid masked to 0 in r, so no pop.
//   - At end of r: count=0, pointers reset, response of the request issued in r-1 discarded.
//   - In r: inst_sram_en=1, addr=redirect_pc (queue flushed, so credit exists).
//   - fetch_pc <= redirect_pc+4. First target entry valid in r+2.
//   - Back-to-back redirects: the last one wins, each discards the previous one's response.
//  Ordering: entries leave strictly in fetch order; none lost or duplicated without redirect.
// CONFIGURATION
//  FQ_ADEL_EN defined:
//   - Fetch of PC with pc[1:0]!=0 drives no SRAM access (inst_sram_en=0).
//   - Instead pushes one entry {adel=1, inst=0, pc}; adel is the bus MSB, BUS_W=DATA_W+PC_W+1.
//   - Fetch then halts (no issue) until the next redirect.
//   - Aligned entries carry adel=0.
//  FQ_ADEL_EN undefined:
//   - No check; BUS_W=DATA_W+PC_W.
//   - inst_sram_addr = fetch_pc unmodified.
// TESTING (DEPTH=4)
//  1 Release reset, ds_allowin=1 -> addr bfc00000,bfc00004,... each cycle; valid from cycle 2, bus={rdata,pc} in order.
//  2 ds_allowin=0 for 10 cycles -> exactly 4 entries, fq_count=4, inst_sram_en=0 once full; release -> 4 drain in order, fetch resumes gap-free.
//  3 Full queue + redirect to 80000100 -> valid=0 that cycle, fq_count=0 next; next head pc=80000100 two cycles later, no stale pc.
//  4 Redirect with request in flight and ds_allowin=1 -> stale response dropped; no pop that cycle; target entries only.
//  5 FQ_ADEL_EN: redirect to 80000102 -> inst_sram_en=0; one entry adel=1 pc=80000102; no requests until redirect to 80000200.
//  6 Drop resetn mid-stream -> en/valid/fq_count 0 same cycle; after release fetch restarts at bfc00000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction SRAM request/response, redirect,
// and the fetch-to-decode handshake.
// The master side is the fetch queue. The slave side is the SRAM/ID environment.
interface fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int BUS_W  = DATA_W + PC_W,
    parameter int CNT_W  = 3
);
    logic              inst_sram_en;
    logic [3:0]        inst_sram_wen;
    logic [PC_W-1:0]   inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic [DATA_W-1:0] inst_sram_rdata;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              ds_allowin;
    logic              fs_to_ds_valid;
    logic [BUS_W-1:0]  fs_to_ds_bus;
    logic [CNT_W-1:0]  fq_count;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output fs_to_ds_valid, fs_to_ds_bus, fq_count,
        input  inst_sram_rdata, redirect_valid, redirect_pc, ds_allowin
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  fs_to_ds_valid, fs_to_ds_bus, fq_count,
        output inst_sram_rdata, redirect_valid, redirect_pc, ds_allowin
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end with a DEPTH-entry decoupling queue.
// It owns the fetch PC and issues one SRAM read per cycle while credit allows.
// It buffers {inst, pc} entries and hands them to ID via valid/allowin.
// A redirect flushes the queue and any in-flight response, then restarts at the target.
//
// Optional feature macro: FQ_ADEL_EN.
// - When it is defined, a misaligned fetch does not access the SRAM.
// - Instead it queues one {adel=1, inst=0, pc} entry. The adel flag is the bus MSB.
// - Fetch then halts until the next redirect.
module fetch_queue #(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'hbfc00000)
) (
    input logic            clk,
    input logic            resetn,
    fetch_queue_if.master  fq
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
`ifdef FQ_ADEL_EN
    localparam int BUS_W = DATA_W + PC_W + 1;
`else
    localparam int BUS_W = DATA_W + PC_W;
`endif

    logic [PC_W-1:0]  fetch_pc;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             halted;
    logic [BUS_W-1:0] mem [DEPTH];

    // Request issued last cycle, whose response arrives this cycle
    logic             vld_p1;
    logic [PC_W-1:0]  pc_p1;
`ifdef FQ_ADEL_EN
    logic             adel_p1;
`endif

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             credit;
    logic             fetch;
    logic             misaligned;
    logic [CNT_W:0]   occupancy;
    logic [PC_W-1:0]  fetch_addr;
    logic [BUS_W-1:0] entry;

    // Handshake, credit and fetch-address selection
    always_comb begin
        head_valid = (count != '0) && !fq.redirect_valid;
        pop        = head_valid && fq.ds_allowin;
        push       = vld_p1 && !fq.redirect_valid;
        // Slots already committed: queued entries plus the in-flight response,
        // minus the entry leaving this cycle.
        occupancy  = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
        credit     = occupancy < (CNT_W+1)'(DEPTH);
        fetch_addr = fq.redirect_valid ? fq.redirect_pc : fetch_pc;
        // A redirect always fetches, because the flush frees the whole queue.
        fetch      = fq.redirect_valid || (!halted && credit);
`ifdef FQ_ADEL_EN
        misaligned = (fetch_addr[1:0] != 2'b00);
        entry      = {adel_p1, adel_p1 ? DATA_W'(0) : fq.inst_sram_rdata, pc_p1};
`else
        misaligned = 1'b0;
        entry      = {fq.inst_sram_rdata, pc_p1};
`endif
    end

    assign fq.inst_sram_en    = resetn && fetch && !misaligned;
    assign fq.inst_sram_wen   = 4'b0000;
    assign fq.inst_sram_addr  = fetch_addr;
    assign fq.inst_sram_wdata = 32'h0;
    assign fq.fs_to_ds_valid  = head_valid;
    assign fq.fs_to_ds_bus    = mem[head];
    assign fq.fq_count        = count;

    // Control state: fetch PC, occupancy, pointers, in-flight flag, halt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            vld_p1   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            vld_p1 <= fetch;
            if (fetch)
                fetch_pc <= fetch_addr + PC_W'(4);
            if (fq.redirect_valid) begin
                count  <= '0;
                head   <= '0;
                tail   <= '0;
                halted <= misaligned;
            end else begin
                if (push)
                    tail <= tail + AW'(1);
                if (pop)
                    head <= head + AW'(1);
                count  <= count + CNT_W'(push) - CNT_W'(pop);
                halted <= halted || (fetch && misaligned);
            end
        end
    end

    // Datapath: request tag for the in-flight response and queue storage
    always_ff @(posedge clk) begin
        if (fetch) begin
            pc_p1   <= fetch_addr;
`ifdef FQ_ADEL_EN
            adel_p1 <= misaligned;
`endif
        end
        if (push)
            mem[tail] <= entry;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (DEPTH=4).
// Random SRAM data and random stall/redirect traffic drive the design.
// The outputs are compared each cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
`ifdef FQ_ADEL_EN
    localparam int BUS_W  = DATA_W + PC_W + 1;
`else
    localparam int BUS_W  = DATA_W + PC_W;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .BUS_W(BUS_W), .CNT_W(CNT_W)) ifc ();

    fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(32'hbfc00000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fq     (ifc)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: expected queue contents, one pending request, next PC.
    logic [BUS_W-1:0] mq[$];
    bit               m_pend;
    logic [31:0]      m_pend_pc;
    bit               m_pend_adel;
    logic [31:0]      m_pc;
    bit               m_halt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend      = 1'b0;
        m_pend_pc   = '0;
        m_pend_adel = 1'b0;
        m_pc        = 32'hbfc00000;
        m_halt      = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit allow, input bit redir, input logic [31:0] rpc);
        logic [31:0]      rd;
        logic [31:0]      fa;
        logic [BUS_W-1:0] ent;
        bit               exp_valid;
        bit               pop;
        bit               fetch;
        bit               mis;
        bit               exp_en;
        int               occ;
        rd = $urandom;
        ifc.ds_allowin      = allow;
        ifc.redirect_valid  = redir;
        ifc.redirect_pc     = rpc;
        ifc.inst_sram_rdata = rd;
        #1;
        exp_valid = (mq.size() > 0) && !redir;
        pop       = exp_valid && allow;
        fa        = redir ? rpc : m_pc;
        occ       = mq.size() + int'(m_pend) - int'(pop);
        fetch     = redir || (!m_halt && occ < DEPTH);
`ifdef FQ_ADEL_EN
        mis       = (fa % 4) != 0;
`else
        mis       = 1'b0;
`endif
        exp_en    = fetch && !mis;
        chk("inst_sram_en", ifc.inst_sram_en, exp_en);
        if (exp_en)
            chk("inst_sram_addr", ifc.inst_sram_addr, fa);
        chk("fs_to_ds_valid", ifc.fs_to_ds_valid, exp_valid);
        if (exp_valid)
            chk("fs_to_ds_bus", ifc.fs_to_ds_bus, mq[0]);
        chk("fq_count", ifc.fq_count, mq.size());
        chk("inst_sram_wen", ifc.inst_sram_wen, 4'b0000);
`ifdef FQ_ADEL_EN
        ent = {m_pend_adel, m_pend_adel ? 32'h0 : rd, m_pend_pc};
`else
        ent = {rd, m_pend_pc};
`endif
        if (redir) begin
            mq.delete();
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (m_pend)
                mq.push_back(ent);
        end
        m_pend      = fetch;
        m_pend_pc   = fa;
        m_pend_adel = mis;
        if (fetch)
            m_pc = fa + 32'd4;
        m_halt = redir ? mis : (m_halt || (fetch && mis));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        ifc.ds_allowin      = 1'b0;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_pc     = '0;
        ifc.inst_sram_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_en", ifc.inst_sram_en, 1'b0);
        chk("reset_valid", ifc.fs_to_ds_valid, 1'b0);
        chk("reset_count", ifc.fq_count, 3'd0);
        resetn = 1'b1;

        // Streaming with ID always ready
        chk("first_addr", ifc.inst_sram_addr, 32'hbfc00000);
        repeat (12) step(1'b1, 1'b0, '0);

        // ID stalls: the queue fills to DEPTH and fetch stops, then drains in order
        repeat (10) step(1'b0, 1'b0, '0);
        chk("full_count", ifc.fq_count, 3'd4);
        chk("full_no_fetch", ifc.inst_sram_en, 1'b0);
        repeat (10) step(1'b1, 1'b0, '0);

        // Redirect while full
        repeat (6) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h80000100);
        chk("flush_count", ifc.fq_count, 3'd0);
        repeat (6) step(1'b1, 1'b0, '0);

        // Redirect with a request in flight, then back-to-back redirects
        step(1'b1, 1'b1, 32'h80000300);
        step(1'b1, 1'b1, 32'h80000400);
        step(1'b1, 1'b1, 32'h80000500);
        repeat (6) step(1'b1, 1'b0, '0);

        // Fetch-address wrap at the top of the address space
        step(1'b1, 1'b1, 32'hfffffff8);
        repeat (6) step(1'b1, 1'b0, '0);

`ifdef FQ_ADEL_EN
        // Misaligned target: one adel entry, then no fetch until the next redirect
        step(1'b1, 1'b1, 32'h80000102);
        repeat (6) step(1'b0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h80000200);
        repeat (6) step(1'b1, 1'b0, '0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
`ifndef FQ_ADEL_EN
            t = t & 32'hfffffffc;
`else
            if ($urandom_range(0, 3) != 0)
                t = t & 32'hfffffffc;
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, t);
        end

        // Asynchronous reset mid-stream
        repeat (5) step(1'b1, 1'b0, '0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_en", ifc.inst_sram_en, 1'b0);
        chk("async_rst_valid", ifc.fs_to_ds_valid, 1'b0);
        chk("async_rst_count", ifc.fq_count, 3'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("restart_addr", ifc.inst_sram_addr, 32'hbfc00000);
        repeat (10) step(1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
